wb_rr_arbiter: RTL and testbench

//  Round-robin arbiter that shares one pipelined Wishbone device port (e.g. the push side of the

---
 rtl/wb_arb_pkg.sv | 13 +
 rtl/rr_pick.sv | 36 +++
 rtl/wb_rr_arbiter.sv | 144 ++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone round-robin arbiter.
//   arb_state_t  : arbiter FSM state (IDLE, GRANT)
//   outst_width  : width of the outstanding-transfer counter for a given limit
package wb_arb_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  // One extra bit so the counter can hold the full limit value itself.
  function automatic int unsigned outst_width(int unsigned max_outst);
    return $clog2(max_outst) + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker. Searches req_i starting one past last_i, wrapping,
// and returns the first set bit.
//   req_i      : request vector
//   last_i     : index of the previous winner (lowest priority this round)
//   win_o      : one-hot winner, zero when no request
//   win_idx_o  : winner index, zero when no request
module rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]                       req_i,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0] last_i,
  output logic [N-1:0]                       win_o,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] win_idx_o
);

  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  logic [IdxW-1:0] cand;
  logic            found;

  always_comb begin
    win_o     = '0;
    win_idx_o = '0;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IdxW'((32'(last_i) + k) % N);
      if (!found && req_i[cand]) begin
        found     = 1'b1;
        win_idx_o = cand;
      end
    end
    if (found) win_o[win_idx_o] = 1'b1;
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone device port between N_REQ controllers.
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   req_cyc_i/stb_i/dat_i    : per-controller Wishbone master signals
//   req_stall_o/ack_o        : per-controller stall and ack
//   dev_cyc_o/stb_o/dat_o    : muxed signals to the device
//   dev_stall_i/ack_i        : device stall and ack
//   grant_o                  : one-hot current owner, zero while idle
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_OUTST  = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [N_REQ-1:0]                 req_cyc_i,
  input  logic [N_REQ-1:0]                 req_stb_i,
  input  logic [N_REQ-1:0][DATA_WIDTH-1:0] req_dat_i,
  output logic [N_REQ-1:0]                 req_stall_o,
  output logic [N_REQ-1:0]                 req_ack_o,
  output logic                             dev_cyc_o,
  output logic                             dev_stb_o,
  output logic [DATA_WIDTH-1:0]            dev_dat_o,
  input  logic                             dev_stall_i,
  input  logic                             dev_ack_i,
  output logic [N_REQ-1:0]                 grant_o
);

  localparam int unsigned     IdxW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned     OutW    = outst_width(MAX_OUTST);
  localparam logic [IdxW-1:0] LastRst = IdxW'(N_REQ - 1);
  localparam logic [OutW-1:0] OutMax  = OutW'(MAX_OUTST);

  arb_state_t        state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  // While in GRANT, last_q is also the current owner's index.
  logic [IdxW-1:0]   last_q, last_d;
  logic [OutW-1:0]   outst_q, outst_d;

  logic [N_REQ-1:0]  win;
  logic [IdxW-1:0]   win_idx;
  logic              full;
  logic              accept;
  logic              ack_valid;

  rr_pick #(
    .N (N_REQ)
  ) u_rr_pick (
    .req_i     (req_cyc_i),
    .last_i    (last_q),
    .win_o     (win),
    .win_idx_o (win_idx)
  );

  assign full    = (outst_q == OutMax);
  assign accept  = dev_stb_o & ~dev_stall_i;
  // Acks only count (and are forwarded) while something is outstanding, so stale acks
  // left over from an aborted owner never reach the next owner.
  assign ack_valid = dev_ack_i & (outst_q != '0);
  assign grant_o   = grant_q;

  always_comb begin
    dev_cyc_o   = 1'b0;
    dev_stb_o   = 1'b0;
    dev_dat_o   = '0;
    req_stall_o = req_stb_i;
    req_ack_o   = '0;
    if (state_q == GRANT) begin
      dev_cyc_o           = req_cyc_i[last_q];
      dev_stb_o           = req_stb_i[last_q] & ~full;
      dev_dat_o           = req_dat_i[last_q];
      req_stall_o[last_q] = dev_stall_i | full;
      req_ack_o[last_q]   = ack_valid;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    outst_d = outst_q;
    unique case (state_q)
      IDLE: begin
        outst_d = '0;
        if (|req_cyc_i) begin
          state_d = GRANT;
          grant_d = win;
          last_d  = win_idx;
        end
      end
      GRANT: begin
        if (!req_cyc_i[last_q]) begin
          // Owner ended (or aborted) its cycle; pending acks are forgotten.
          state_d = IDLE;
          grant_d = '0;
          outst_d = '0;
        end else if (accept && !ack_valid) begin
          outst_d = outst_q + OutW'(1);
        end else if (!accept && ack_valid) begin
          outst_d = outst_q - OutW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LastRst;
      outst_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      outst_q <= outst_d;
    end
  end

`ifdef FORMAL
  localparam logic [IdxW:0] CovDone = (IdxW + 1)'(N_REQ);
  logic [IdxW:0] cov_q;

  // Advances each time the next index in order holds the grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cov_q <= '0;
    end else if (cov_q != CovDone && grant_q[cov_q[IdxW-1:0]]) begin
      cov_q <= cov_q + 1'b1;
    end
  end

  always_comb begin
    if (rst_ni) begin
      assert ($onehot0(grant_o));
      assert (outst_q <= OutMax);
      assert ((req_ack_o & ~grant_o) == '0);
      cover (cov_q == CovDone);
    end
  end
`endif

endmodule

// File: tb/tb_wb_rr_arbiter.sv
module tb_wb_rr_arbiter;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int MAXO = 4;
  localparam int IW   = 2;

  logic                 clk = 1'b0;
  logic                 rst_ni = 1'b0;
  logic [N-1:0]         cyc, stb;
  logic [N-1:0][DW-1:0] dat;
  logic                 dstall, dack;
  logic [N-1:0]         stall_o, ack_o, grant;
  logic                 dev_cyc, dev_stb;
  logic [DW-1:0]        dev_dat;

  int total = 0;
  int bad   = 0;

  // Behavioural model: owner index (-1 = nobody), last winner, outstanding count.
  int m_owner = -1;
  int m_last  = N - 1;
  int m_outst = 0;
  int m_acc   = 0;
  int d_acc   = 0;
  int grant_log[$];

  logic [N-1:0]  e_grant, e_stall, e_ack;
  logic          e_cyc, e_stb;
  logic [DW-1:0] e_dat;
  logic [IW-1:0] oi;

  int order[5] = '{0, 1, 2, 3, 0};
  int g;

  wb_rr_arbiter #(
    .N_REQ      (N),
    .DATA_WIDTH (DW),
    .MAX_OUTST  (MAXO)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .req_cyc_i   (cyc),
    .req_stb_i   (stb),
    .req_dat_i   (dat),
    .req_stall_o (stall_o),
    .req_ack_o   (ack_o),
    .dev_cyc_o   (dev_cyc),
    .dev_stb_o   (dev_stb),
    .dev_dat_o   (dev_dat),
    .dev_stall_i (dstall),
    .dev_ack_i   (dack),
    .grant_o     (grant)
  );

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] ix(int i);
    return IW'(i);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_outst = 0;
  endtask

  // One clock edge of the arbiter, from the rules: pick next requester after last,
  // hold while owner's cyc stays high, count accepted strobes minus counted acks.
  task automatic m_step();
    int acc, ak;
    if (m_owner < 0) begin
      for (int k = 1; k <= N; k++)
        if (m_owner < 0 && cyc[ix((m_last + k) % N)]) m_owner = (m_last + k) % N;
      if (m_owner >= 0) begin
        m_last = m_owner;
        grant_log.push_back(m_owner);
      end
      m_outst = 0;
    end else if (!cyc[ix(m_owner)]) begin
      m_owner = -1;
      m_outst = 0;
    end else begin
      acc = (stb[ix(m_owner)] && m_outst < MAXO && !dstall) ? 1 : 0;
      ak  = (dack && m_outst > 0) ? 1 : 0;
      m_acc   += acc;
      m_outst += acc - ak;
    end
  endtask

  // Compare process: outputs are checked mid-cycle, then the model takes the coming edge.
  always @(negedge clk) begin
    if (!rst_ni) m_reset();
    e_grant = '0;
    e_cyc   = 1'b0;
    e_stb   = 1'b0;
    e_dat   = '0;
    e_stall = stb;
    e_ack   = '0;
    if (m_owner >= 0) begin
      oi          = ix(m_owner);
      e_grant[oi] = 1'b1;
      e_cyc       = cyc[oi];
      e_stb       = stb[oi] && (m_outst < MAXO);
      e_dat       = dat[oi];
      e_stall[oi] = dstall || (m_outst == MAXO);
      e_ack[oi]   = dack && (m_outst > 0);
    end
    chk("cmp_grant", grant, e_grant);
    chk("cmp_dev_cyc", dev_cyc, e_cyc);
    chk("cmp_dev_stb", dev_stb, e_stb);
    chk("cmp_dev_dat", dev_dat, e_dat);
    chk("cmp_stall", stall_o, e_stall);
    chk("cmp_ack", ack_o, e_ack);
    if (dev_stb && !dstall) d_acc++;
    if (rst_ni) m_step();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    cyc    = '0;
    stb    = '0;
    dat    = '0;
    dstall = 1'b0;
    dack   = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    idle_bus();
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  initial begin
    // Reset values; stall mirrors stb while idle.
    idle_bus();
    stb = 4'b1010;
    #2;
    chk("rst_grant", grant, 0);
    chk("rst_dev_cyc", dev_cyc, 0);
    chk("rst_stall", stall_o, 4'b1010);
    stb = '0;
    tick();
    tick();
    rst_ni = 1'b1;

    // 1: single controller, one transfer.
    cyc[0] = 1'b1;
    stb[0] = 1'b1;
    dat[0] = 8'hA5;
    #1;
    chk("t1_idle_grant", grant, 0);
    chk("t1_idle_stall", stall_o, 4'b0001);
    tick();
    #1;
    chk("t1_grant", grant, 4'b0001);
    chk("t1_dat", dev_dat, 8'hA5);
    chk("t1_stb", dev_stb, 1);
    tick();
    stb[0] = 1'b0;
    dack   = 1'b1;
    #1;
    chk("t1_ack", ack_o, 4'b0001);
    tick();
    dack   = 1'b0;
    cyc[0] = 1'b0;
    tick();
    #1;
    chk("t1_release", grant, 0);

    // 2: all request, each does one transfer then drops.
    do_reset();
    grant_log.delete();
    cyc = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      #1;
      chk("t2_grant", grant, 4'b0001 << order[k]);
      chk("t2_model_order", m_owner, order[k]);
      g = (m_owner < 0) ? 0 : m_owner;
      stb[ix(g)] = 1'b1;
      dat[ix(g)] = 8'($urandom);
      tick();
      stb[ix(g)] = 1'b0;
      dack       = 1'b1;
      #1;
      chk("t2_ack", ack_o, 4'b0001 << g);
      tick();
      dack       = 1'b0;
      cyc[ix(g)] = 1'b0;
      tick();
      cyc[ix(g)] = 1'b1;
    end
    chk("t2_log_len", grant_log.size(), 5);
    idle_bus();
    tick();

    // 3: owner 2 streams with no acks; limit of 4 outstanding.
    do_reset();
    cyc[2] = 1'b1;
    tick();
    #1;
    chk("t3_grant", grant, 4'b0100);
    m_acc = 0;
    d_acc = 0;
    stb[2] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("t3_stb", dev_stb, (i < 4) ? 1 : 0);
      chk("t3_stall", stall_o[2], (i < 4) ? 0 : 1);
      tick();
    end
    chk("t3_model_acc4", m_acc, 4);
    chk("t3_dut_acc4", d_acc, 4);
    dack = 1'b1;
    #1;
    chk("t3_ack", ack_o, 4'b0100);
    chk("t3_full_stb", dev_stb, 0);
    tick();
    dack = 1'b0;
    tick();
    tick();
    tick();
    chk("t3_model_acc5", m_acc, 5);
    chk("t3_dut_acc5", d_acc, 5);
    idle_bus();
    tick();

    // 4: owner 1 aborts with 2 acks pending, controller 3 waiting.
    do_reset();
    cyc[1] = 1'b1;
    tick();
    #1;
    chk("t4_grant1", grant, 4'b0010);
    cyc[3] = 1'b1;
    stb[1] = 1'b1;
    tick();
    tick();
    stb[1] = 1'b0;
    cyc[1] = 1'b0;
    tick();
    #1;
    chk("t4_idle", grant, 0);
    tick();
    #1;
    chk("t4_grant3", grant, 4'b1000);
    dack = 1'b1;
    #1;
    chk("t4_late_ack0", ack_o, 0);
    tick();
    #1;
    chk("t4_late_ack1", ack_o, 0);
    tick();
    dack   = 1'b0;
    stb[3] = 1'b1;
    #1;
    chk("t4_stb3", dev_stb, 1);
    tick();
    stb[3] = 1'b0;
    dack   = 1'b1;
    #1;
    chk("t4_ack3", ack_o, 4'b1000);
    tick();
    idle_bus();
    tick();

    // 5: non-owner 0 strobes during owner 3's burst.
    do_reset();
    cyc[3] = 1'b1;
    tick();
    #1;
    chk("t5_grant3", grant, 4'b1000);
    cyc[0] = 1'b1;
    stb[0] = 1'b1;
    dat[0] = 8'h11;
    stb[3] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      dat[3] = 8'h40 + 8'(i);
      dack   = (i > 0);
      #1;
      chk("t5_stall0", stall_o[0], 1);
      chk("t5_dat", dev_dat, 8'h40 + i);
      chk("t5_ack0", ack_o[0], 0);
      tick();
    end
    stb[3] = 1'b0;
    dack   = 1'b0;
    cyc[3] = 1'b0;
    tick();
    tick();
    #1;
    chk("t5_grant0", grant, 4'b0001);
    chk("t5_dat0", dev_dat, 8'h11);
    idle_bus();
    tick();

    // 6: asynchronous reset mid-transfer.
    do_reset();
    cyc[2] = 1'b1;
    stb[2] = 1'b1;
    tick();
    tick();
    #2;
    rst_ni = 1'b0;
    #1;
    chk("t6_grant", grant, 0);
    chk("t6_dev_cyc", dev_cyc, 0);
    chk("t6_dev_stb", dev_stb, 0);
    chk("t6_stall", stall_o, 4'b0100);
    cyc = 4'b1111;
    stb = '0;
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
    #1;
    chk("t6_first", grant, 4'b0001);
    idle_bus();
    tick();

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 9) == 0) cyc[ix(i)] = ~cyc[ix(i)];
        stb[ix(i)] = cyc[ix(i)] & 1'($urandom_range(0, 1));
        dat[ix(i)] = 8'($urandom);
      end
      dstall = ($urandom_range(0, 3) == 0);
      dack   = ($urandom_range(0, 2) == 0);
      tick();
    end
    idle_bus();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
